// File: rtl/phase_scheduler_if.sv
// rtl/phase_scheduler_if.sv - signal bundle between the intersection controller and the phase scheduler
interface phase_scheduler_if #(
   parameter int CW = 7
);
   logic          tick;
   logic          A_Traffic;
   logic          B_Traffic;
   logic          A_Req;
   logic          B_Req;
   logic [1:0]    A_Light;
   logic [1:0]    B_Light;
   logic [CW-1:0] second;
   logic [2:0]    phase;
   logic          preempt;

   modport master (
      output tick, A_Traffic, B_Traffic, A_Req, B_Req,
      input  A_Light, B_Light, second, phase, preempt
   );

   modport slave (
      input  tick, A_Traffic, B_Traffic, A_Req, B_Req,
      output A_Light, B_Light, second, phase, preempt
   );
endinterface

// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - two-approach green/yellow/all-red scheduler with force requests and idle-green cutoff
module phase_scheduler #(
   parameter int CW         = 7,
   parameter int GREEN_A    = 90,
   parameter int GREEN_B    = 30,
   parameter int YELLOW     = 5,
   parameter int ALLRED     = 2,
   parameter int MIN_GREEN  = 10,
   parameter int IDLE_LIMIT = 5
) (
   input logic               CLK,
   input logic               R,
   phase_scheduler_if.slave  bus
);
   typedef enum logic [2:0] {
      AG = 3'd0,
      AY = 3'd1,
      AR = 3'd2,
      BG = 3'd3,
      BY = 3'd4,
      BR = 3'd5
   } state_t;

   localparam int IW = $clog2(IDLE_LIMIT + 1);

   localparam logic [CW:0]   GA_N   = (CW+1)'(GREEN_A);
   localparam logic [CW:0]   GB_N   = (CW+1)'(GREEN_B);
   localparam logic [CW:0]   Y_N    = (CW+1)'(YELLOW);
   localparam logic [CW:0]   AR_N   = (CW+1)'(ALLRED);
   localparam logic [CW:0]   MIN_N  = (CW+1)'(MIN_GREEN);
   localparam logic [IW:0]   IDLE_N = (IW+1)'(IDLE_LIMIT);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIMIT);

   state_t        state, state_nx;
   logic [CW-1:0] sec, sec_nx;
   logic [IW-1:0] idle_a, idle_a_nx, idle_b, idle_b_nx;
   logic          pre, pre_nx;

   logic [CW:0]   n;
   logic [IW:0]   idle_a_n, idle_b_n;
   logic          trunc_a, expire_a, idle_end_a;
   logic          trunc_b, expire_b, idle_end_b;

   // n is the second count including the current tick, one bit wider so it never wraps
   assign n        = {1'b0, sec} + 1'b1;
   assign idle_a_n = {1'b0, idle_a} + 1'b1;
   assign idle_b_n = {1'b0, idle_b} + 1'b1;

   assign trunc_a    = bus.B_Req && (n >= MIN_N);
   assign expire_a   = !bus.A_Req && (n >= GA_N);
   assign idle_end_a = !bus.A_Req && (idle_a_n >= IDLE_N) && bus.B_Traffic && (n >= MIN_N);

   assign trunc_b    = bus.A_Req && (n >= MIN_N);
   assign expire_b   = !bus.B_Req && (n >= GB_N);
   assign idle_end_b = !bus.B_Req && (idle_b_n >= IDLE_N) && bus.A_Traffic && (n >= MIN_N);

   always_comb begin
      state_nx  = state;
      sec_nx    = sec;
      idle_a_nx = idle_a;
      idle_b_nx = idle_b;
      pre_nx    = pre;

      case (state)
         AG: if (bus.tick && (trunc_a || expire_a || idle_end_a)) begin
            state_nx = AY;
            pre_nx   = trunc_a;
         end
         AY: if (bus.tick && (n == Y_N)) state_nx = AR;
         AR: if (bus.tick && (n == AR_N)) begin
            state_nx = BG;
            pre_nx   = 1'b0;
         end
         BG: if (bus.tick && (trunc_b || expire_b || idle_end_b)) begin
            state_nx = BY;
            pre_nx   = trunc_b;
         end
         BY: if (bus.tick && (n == Y_N)) state_nx = BR;
         BR: if (bus.tick && (n == AR_N)) begin
            state_nx = AG;
            pre_nx   = 1'b0;
         end
         default: begin
            state_nx = AG;
            pre_nx   = 1'b0;
         end
      endcase

      // Phase entry restarts all per-phase counters; otherwise advance on tick
      if (state_nx != state) begin
         sec_nx    = '0;
         idle_a_nx = '0;
         idle_b_nx = '0;
      end else if (bus.tick) begin
         sec_nx = (sec == '1) ? sec : sec + 1'b1;
         if (state == AG)
            idle_a_nx = bus.A_Traffic ? '0 : ((idle_a == IDLE_MAX) ? idle_a : idle_a + 1'b1);
         if (state == BG)
            idle_b_nx = bus.B_Traffic ? '0 : ((idle_b == IDLE_MAX) ? idle_b : idle_b + 1'b1);
      end
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         state  <= AG;
         sec    <= '0;
         idle_a <= '0;
         idle_b <= '0;
         pre    <= 1'b0;
      end else begin
         state  <= state_nx;
         sec    <= sec_nx;
         idle_a <= idle_a_nx;
         idle_b <= idle_b_nx;
         pre    <= pre_nx;
      end
   end

   always_comb begin
      bus.A_Light = 2'b00;
      bus.B_Light = 2'b00;
      case (state)
         AG:      bus.A_Light = 2'b10;
         AY:      bus.A_Light = 2'b01;
         BG:      bus.B_Light = 2'b10;
         BY:      bus.B_Light = 2'b01;
         default: ;
      endcase
   end

   assign bus.second  = sec;
   assign bus.phase   = state;
   assign bus.preempt = pre;
endmodule

// File: tb/tb_phase_scheduler.sv
// tb/tb_phase_scheduler.sv - directed bench for phase_scheduler
module tb_phase_scheduler;
   localparam logic [2:0] P_AG = 3'd0;
   localparam logic [2:0] P_AY = 3'd1;
   localparam logic [2:0] P_AR = 3'd2;
   localparam logic [2:0] P_BG = 3'd3;
   localparam logic [2:0] P_BY = 3'd4;
   localparam logic [2:0] P_BR = 3'd5;

   logic CLK;
   logic R;
   int   checks = 0;
   int   errors = 0;

   phase_scheduler_if #(.CW(7)) ifc ();

   phase_scheduler dut (
      .CLK (CLK),
      .R   (R),
      .bus (ifc)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] eph, input int esec, input logic epre);
      logic [1:0] ea;
      logic [1:0] eb;
      ea = (eph == P_AG) ? 2'b10 : (eph == P_AY) ? 2'b01 : 2'b00;
      eb = (eph == P_BG) ? 2'b10 : (eph == P_BY) ? 2'b01 : 2'b00;
      checks++;
      assert (ifc.phase === eph && ifc.second === 7'(esec) && ifc.preempt === epre &&
              ifc.A_Light === ea && ifc.B_Light === eb)
      else begin
         errors++;
         $error("FAIL %s: got phase=%0d second=%0d preempt=%b A=%b B=%b, want phase=%0d second=%0d preempt=%b A=%b B=%b",
                tag, ifc.phase, ifc.second, ifc.preempt, ifc.A_Light, ifc.B_Light,
                eph, esec, epre, ea, eb);
      end
   endtask

   task automatic run(input string tag, input logic [2:0] ph, input int len, input logic pre);
      for (int i = 0; i < len; i++) begin
         chk(tag, ph, i, pre);
         step();
      end
   endtask

   task automatic rest_from_ay(input string tag, input logic pre);
      run(tag, P_AY, 5, pre);
      run(tag, P_AR, 2, pre);
      run(tag, P_BG, 30, 1'b0);
      run(tag, P_BY, 5, 1'b0);
      run(tag, P_BR, 2, 1'b0);
   endtask

   task automatic full_cycle(input string tag);
      run(tag, P_AG, 90, 1'b0);
      rest_from_ay(tag, 1'b0);
      chk({tag, "_wrap"}, P_AG, 0, 1'b0);
   endtask

   initial begin
      R             = 1'b0;
      ifc.tick      = 1'b1;
      ifc.A_Traffic = 1'b1;
      ifc.B_Traffic = 1'b1;
      ifc.A_Req     = 1'b0;
      ifc.B_Req     = 1'b0;
      step();
      step();
      chk("reset", P_AG, 0, 1'b0);
      @(negedge CLK);
      R = 1'b1;
      chk("release", P_AG, 0, 1'b0);

      full_cycle("default");

      // A empties at second 20 while B waits: green ends on the fifth empty tick
      repeat (20) step();
      ifc.A_Traffic = 1'b0;
      for (int s = 20; s <= 24; s++) begin
         chk("idle_ag", P_AG, s, 1'b0);
         step();
      end
      chk("idle_end", P_AY, 0, 1'b0);
      ifc.A_Traffic = 1'b1;
      rest_from_ay("idle_rest", 1'b0);

      ifc.A_Traffic = 1'b0;
      ifc.B_Traffic = 1'b0;
      run("no_idle", P_AG, 90, 1'b0);
      chk("no_idle_end", P_AY, 0, 1'b0);
      ifc.A_Traffic = 1'b1;
      ifc.B_Traffic = 1'b1;
      rest_from_ay("no_idle_rest", 1'b0);

      // B request at second 3 truncates once minimum green is served
      repeat (3) step();
      ifc.B_Req = 1'b1;
      for (int s = 3; s <= 9; s++) begin
         chk("breq_ag", P_AG, s, 1'b0);
         step();
      end
      chk("trunc", P_AY, 0, 1'b1);
      run("trunc_y", P_AY, 5, 1'b1);
      run("trunc_r", P_AR, 2, 1'b1);
      for (int i = 0; i <= 140; i++) begin
         chk("bg_hold", P_BG, (i > 127) ? 127 : i, 1'b0);
         step();
      end
      ifc.B_Req = 1'b0;
      step();
      chk("hold_release", P_BY, 0, 1'b0);
      run("hr_by", P_BY, 5, 1'b0);
      run("hr_br", P_BR, 2, 1'b0);
      run("hr_ag", P_AG, 90, 1'b0);
      run("hr_ay", P_AY, 5, 1'b0);
      run("hr_ar", P_AR, 2, 1'b0);

      // Contested green at BG second 15
      repeat (15) step();
      chk("bg15", P_BG, 15, 1'b0);
      ifc.A_Req = 1'b1;
      ifc.B_Req = 1'b1;
      step();
      chk("both", P_BY, 0, 1'b1);
      run("both_by", P_BY, 5, 1'b1);
      run("both_br", P_BR, 2, 1'b1);
      for (int s = 0; s <= 9; s++) begin
         chk("contest_ag", P_AG, s, 1'b0);
         step();
      end
      chk("contest_end", P_AY, 0, 1'b1);

      // Asynchronous reset in the middle of BY
      ifc.A_Req = 1'b0;
      ifc.B_Req = 1'b0;
      run("pre_rst_ay", P_AY, 5, 1'b1);
      run("pre_rst_ar", P_AR, 2, 1'b1);
      run("pre_rst_bg", P_BG, 30, 1'b0);
      step();
      step();
      chk("by2", P_BY, 2, 1'b0);
      #3;
      R = 1'b0;
      #1;
      chk("async_rst", P_AG, 0, 1'b0);
      step();
      chk("rst_held", P_AG, 0, 1'b0);
      @(negedge CLK);
      R = 1'b1;
      full_cycle("post_rst");

      // Tick on every third clock
      ifc.tick = 1'b0;
      step();
      step();
      chk("no_tick", P_AG, 0, 1'b0);
      repeat (12) begin
         ifc.tick = 1'b1;
         step();
         ifc.tick = 1'b0;
         step();
         step();
      end
      chk("slow12", P_AG, 12, 1'b0);
      ifc.B_Req = 1'b1;
      step();
      ifc.B_Req = 1'b0;
      step();
      ifc.tick = 1'b1;
      step();
      chk("pulse_lost", P_AG, 13, 1'b0);
      repeat (76) begin
         ifc.tick = 1'b0;
         step();
         step();
         ifc.tick = 1'b1;
         step();
      end
      chk("slow89", P_AG, 89, 1'b0);
      ifc.tick = 1'b0;
      step();
      step();
      ifc.tick = 1'b1;
      step();
      chk("slow_ay", P_AY, 0, 1'b0);
      for (int c = 1; c <= 15; c++) begin
         ifc.tick = (c % 3 == 0);
         step();
         chk("slow_yellow", (c < 15) ? P_AY : P_AR, (c < 15) ? c / 3 : 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Two-approach signal-phase scheduler that owns the green right-of-way at the intersection and shares it between approach A and approach B. It runs a fixed green/yellow/all-red sequence timed in seconds from an external one-second strobe. The sequence is modified by forced requests, by idle-green early termination, and by a minimum-green guard. It replaces ad-hoc light sequencing at the top level. It drives the per-approach light encodings plus the elapsed-second count consumed by the BCD display path.

## Interface
Parameters:
- CW, 7, width of `second` and of the internal duration compares
- GREEN_A, 90, nominal A green length in seconds
- GREEN_B, 30, nominal B green length in seconds
- YELLOW, 5, yellow length in seconds, both approaches
- ALLRED, 2, all-red clearance length in seconds
- MIN_GREEN, 10, minimum green before any truncation; must be ≤ GREEN_A and ≤ GREEN_B
- IDLE_LIMIT, 5, consecutive empty-approach seconds that end a green early

Ports:
- CLK  in  1  sole clock; all state updates on posedge
- R  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle one-second strobe; all timing advances only on cycles where tick=1
- A_Traffic  in  1  1 = vehicles present on A, 0 = A empty
- B_Traffic  in  1  1 = vehicles present on B, 0 = B empty
- A_Req  in  1  level force request for A green
- B_Req  in  1  level force request for B green
- A_Light  out  2  A light: 00 red, 01 yellow, 10 green
- B_Light  out  2  B light, same encoding
- second  out  CW  seconds elapsed in current phase
- phase  out  3  current state code
- preempt  out  1  current yellow/all-red was caused by a request truncation

## Operation
States and codes:
- AG=0: A green, B red
- AY=1: A yellow, B red
- AR=2: both red
- BG=3: B green, A red
- BY=4: B yellow, A red
- BR=5: both red
- Codes 6 and 7 are unreachable; if entered, next clock goes to AG.
- Sequence: AG→AY→AR→BG→BY→BR→AG. No other transitions.

Phase timing:
- `second` clears to 0 on every phase entry.
- Each tick that does not end the phase increments `second`, saturating at 2^CW−1.
- Let n = second+1, evaluated on a tick cycle. The phase ends on that tick when its end condition holds at n.
- Yellow ends at n==YELLOW. All-red ends at n==ALLRED. Requests and traffic are ignored in yellow and all-red.

Green end conditions, shown for AG; BG mirrors with A and B swapped and GREEN_B:
- (a) Truncation: B_Req=1 and n≥MIN_GREEN. This applies even when A_Req=1, so a contested green always goes to the waiting side.
- (b) Nominal expiry: A_Req=0 and n≥GREEN_A.
- (c) Idle end: A_Req=0, idleA+1≥IDLE_LIMIT, B_Traffic=1, and n≥MIN_GREEN.
- Hold: A_Req=1 and B_Req=0 holds AG indefinitely.

Idle counter (idleA):
- Counts ticks in AG with A_Traffic=0.
- Clears on any tick with A_Traffic=1 and on phase entry.
- Saturates at IDLE_LIMIT.

preempt:
- Set on the green→yellow transition caused by (a).
- Stays 1 through the following yellow and all-red.
- Clears on the next green entry.
- If (a) and (b)/(c) hold together, (a) is the cause and preempt=1.

Outputs:
- All outputs are registered and update on the same edge as `phase`.
- Lights are a pure function of registered state.

## Timing
- Reset (R=0, asynchronous, any cycle including mid-phase), all immediately: phase=0 (AG), A_Light=10, B_Light=00, second=0, preempt=0, idle counters=0.
- After R deasserts, the first tick is processed normally.
- Latency: a tick sampled at edge k updates phase, second and lights at edge k; values are visible after edge k.
- Requests, traffic and tick are sampled only at tick edges. Pulses between ticks are lost.
- With tick permanently 1, the default cycle is 134 clocks: 90+5+2+30+5+2.

## Test plan
- Reset, A_Req=B_Req=0, both traffic=1, tick every cycle:
  - AG for 90 ticks, AY 5, AR 2, BG 30, BY 5, BR 2, then AG again.
  - second reaches 89 in AG, then 0 on AY entry.
  - preempt stays 0.
- In AG with B_Traffic=1, drop A_Traffic to 0 when second=20:
  - idle end at the tick with second=24: AY entered, second=0, preempt=0.
  - Repeat with B_Traffic=0: AG runs to 90.
- Assert B_Req in AG at second=3:
  - AY entered on the tick with second=9 (MIN_GREEN=10); preempt=1 through AY and AR, 0 at BG.
  - Hold B_Req: BG persists past 30, second saturates at 127.
- In BG at second=15, assert A_Req and B_Req together:
  - BY on that tick, preempt=1, then BR, then AG.
  - With both still held, AG truncates at second=9.
- Assert R=0 mid-cycle during BY at second=2:
  - Outputs go to reset values before the next edge.
  - After release, full default sequence from AG second=0.
- tick every 3rd cycle:
  - second advances only on tick cycles; yellow lasts 15 clocks.
  - A B_Req pulse high only between ticks causes no truncation.
